// File: rtl/mux_8to1_rr_arbiter.sv
// Purpose: round-robin arbiter driving the select of the shared 8:1 datapath mux, with bounded hold.
// Latency: 1 cycle from req sampled to gnt/sel/gnt_valid/hold_cnt (all registered).
// Backpressure: none; requests are level-sensitive and never latched, the owner is pre-empted after MAX_HOLD cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, req[i] = requester i wants the mux
//   sel[2:0]   mux select; owner index in GRANT, last owner index while idle
//   gnt[7:0]   one-hot grant, zero when no owner
//   gnt_valid  an owner holds the mux (OR of gnt)
//   hold_cnt   cycles the current owner has held the grant minus 1; 0 when idle
module mux_8to1_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [3:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       vld_q, vld_d;
    logic [3:0] hold_q, hold_d;

    // Returns {found, index}: first set bit of r scanning p, p+1, ... p+7 (mod 8).
    // The loop runs from the far end so the closest hit is the last one written.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [3:0] pick_all;
    logic [3:0] pick_oth;
    logic       grant_en;
    logic [2:0] grant_idx;

    // gnt_q is the owner's one-hot mask, so masking it out leaves only the competitors.
    assign pick_all = rr_pick(req, ptr_q);
    assign pick_oth = rr_pick(req & ~gnt_q, ptr_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        vld_d     = vld_q;
        hold_d    = hold_q;
        grant_en  = 1'b0;
        grant_idx = pick_all[2:0];

        case (state_q)
            IDLE: begin
                if (pick_all[3]) grant_en = 1'b1;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    // Owner released: with req[own] low, req itself is the competitor set,
                    // so hand straight over without an idle bubble when anyone is waiting.
                    if (pick_all[3]) begin
                        grant_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 8'h00;
                        vld_d   = 1'b0;
                        hold_d  = 4'd0;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end else if (pick_oth[3]) begin
                    grant_en  = 1'b1;
                    grant_idx = pick_oth[2:0];
                end
                // else: hold limit reached but nobody waiting, keep owner and saturate
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            state_d = GRANT;
            sel_d   = grant_idx;
            gnt_d   = 8'h01 << grant_idx;
            vld_d   = 1'b1;
            hold_d  = 4'd0;
            ptr_d   = grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            vld_q   <= 1'b0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            hold_q  <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux_8to1_rr_arbiter.sv
// Purpose: self-checking bench for mux_8to1_rr_arbiter against a cycle-level behavioural model.
// Latency: model advances once per rising edge; outputs compared 1 time unit after the edge.
// Backpressure: not applicable; req is driven freely each cycle.
module tb_mux_8to1_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    int n_tests;
    int n_fail;

    // Behavioural model: owner index (-1 = nobody), number of cycles the owner has held,
    // search start pointer and last select value.
    int m_own;
    int m_held;
    int m_ptr;
    int m_sel;

    mux_8to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int skip);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (m_ptr + i) % 8;
            if (r[k] && k != skip) return k;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_own  = w;
        m_held = 1;
        m_ptr  = (w + 1) % 8;
        m_sel  = w;
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_held = 0;
        m_ptr  = 0;
        m_sel  = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int w;
        if (m_own < 0) begin
            w = pick(r, -1);
            if (w >= 0) model_grant(w);
        end else if (!r[m_own]) begin
            w = pick(r, -1);
            if (w >= 0) model_grant(w);
            else begin
                m_own  = -1;
                m_held = 0;
            end
        end else if (m_held < MAX_HOLD) begin
            m_held++;
        end else begin
            w = pick(r, m_own);
            if (w >= 0) model_grant(w);
        end
    endtask

    task automatic compare_all(input string where);
        int exp_gnt;
        exp_gnt = (m_own < 0) ? 0 : (1 << m_own);
        check({where, ".gnt"},       int'(gnt),       exp_gnt);
        check({where, ".sel"},       int'(sel),       m_sel);
        check({where, ".gnt_valid"}, int'(gnt_valid), (m_own >= 0) ? 1 : 0);
        check({where, ".hold_cnt"},  int'(hold_cnt),  (m_own < 0) ? 0 : m_held - 1);
    endtask

    task automatic cycle(input logic [7:0] r, input string where);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        compare_all(where);
    endtask

    task automatic do_reset(input logic [7:0] r);
        req   = r;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        #1;
        compare_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        n_tests = 0;
        n_fail  = 0;
        req     = 8'h00;
        rst_n   = 1'b0;
        model_reset();

        // 1. Reset with all requesting, first grant goes to 0.
        do_reset(8'hFF);
        cycle(8'hFF, "t1_first");
        check("t1_gnt01", int'(gnt), 8'h01);

        // 2. Single requester saturates hold_cnt, sel stays after release.
        do_reset(8'h00);
        for (int i = 0; i < 10; i++) cycle(8'h20, "t2_hold");
        check("t2_sat", int'(hold_cnt), MAX_HOLD - 1);
        cycle(8'h00, "t2_release");
        check("t2_sel_kept", int'(sel), 5);

        // 3. Fairness with all requesting: each owner gets exactly MAX_HOLD cycles.
        do_reset(8'h00);
        for (int i = 0; i < 8 * MAX_HOLD + 2; i++) begin
            cycle(8'hFF, "t3_rotate");
            check("t3_owner", int'(sel), (i / MAX_HOLD) % 8);
        end

        // 4. Early release hands over with no idle cycle.
        do_reset(8'h00);
        cycle(8'h81, "t4_a");
        cycle(8'h81, "t4_b");
        cycle(8'h80, "t4_handoff");
        check("t4_gnt80", int'(gnt), 8'h80);

        // 5. Pointer wrap after owner 7.
        do_reset(8'h00);
        cycle(8'h80, "t5_own7");
        cycle(8'h0A, "t5_wrap");
        check("t5_sel1", int'(sel), 1);
        cycle(8'h08, "t5_next");
        check("t5_sel3", int'(sel), 3);

        // 6. Mid-grant asynchronous reset, then pointer restarts at 0.
        do_reset(8'h00);
        for (int i = 0; i < 3; i++) cycle(8'h10, "t6_own4");
        check("t6_hold2", int'(hold_cnt), 2);
        mid_reset_pulse();
        cycle(8'h30, "t6_after");
        check("t6_sel4", int'(sel), 4);

        // Randomised traffic: sticky request patterns with occasional changes and resets.
        do_reset(8'h00);
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = r ^ (8'h01 << $urandom_range(0, 7));
                default: r = r;
            endcase
            cycle(r, "rand");
            if ($urandom_range(0, 499) == 0) mid_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
